// File: rtl/fetch_stage.sv
// Instruction-fetch stage with the IF/ID pipeline register.
// Holds the PC, inserts bubbles on memory wait states, flushes on branch and counts stalls.
module fetch_stage #(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned INSTR_W  = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned PC_INC   = 2,
    parameter int unsigned CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pc_write,
    input  logic               ifid_write,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_ready,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic [ADDR_W-1:0]  ifid_pc,
    output logic [ADDR_W-1:0]  ifid_pc_plus,
    output logic               ifid_valid,
    output logic [3:0]         ifid_rs,
    output logic [3:0]         ifid_rt,
    output logic               fetch_stall,
    output logic [CNT_W-1:0]   stall_count
);

    localparam logic [ADDR_W-1:0] PcStep = ADDR_W'(PC_INC);
    localparam logic [CNT_W-1:0]  CntMax = '1;

    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  pc_seq;
    logic [ADDR_W-1:0]  redirect_pc;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  ifpc_q, ifpc_d;
    logic [ADDR_W-1:0]  ifplus_q, ifplus_d;
    logic               valid_q, valid_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               stall_cycle;

    assign pc_seq      = pc_q + PcStep;
    // Instruction addresses are halfword aligned; the target's bit 0 is discarded.
    assign redirect_pc = {branch_target[ADDR_W-1:1], 1'b0};

    always_comb begin
        pc_d = pc_q;
        if (branch_taken) begin
            pc_d = redirect_pc;
        end else if (pc_write && imem_ready) begin
            pc_d = pc_seq;
        end
    end

    always_comb begin
        instr_d  = instr_q;
        ifpc_d   = ifpc_q;
        ifplus_d = ifplus_q;
        valid_d  = valid_q;
        if (branch_taken) begin
            instr_d = '0;
            valid_d = 1'b0;
        end else if (ifid_write) begin
            if (imem_ready) begin
                instr_d  = imem_rdata;
                ifpc_d   = pc_q;
                ifplus_d = pc_seq;
                valid_d  = 1'b1;
            end else begin
                instr_d = '0;
                valid_d = 1'b0;
            end
        end
    end

    // A redirect edge is not a stall even if the hazard unit is also holding.
    assign stall_cycle = (~pc_write | ~imem_ready) & ~branch_taken;

    always_comb begin
        cnt_d = cnt_q;
        if (stall_cycle && (cnt_q != CntMax)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            instr_q  <= '0;
            ifpc_q   <= '0;
            ifplus_q <= '0;
            valid_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            ifpc_q   <= ifpc_d;
            ifplus_q <= ifplus_d;
            valid_q  <= valid_d;
            cnt_q    <= cnt_d;
        end
    end

    assign imem_addr    = pc_q;
    assign fetch_stall  = ~imem_ready;
    assign ifid_instr   = instr_q;
    assign ifid_pc      = ifpc_q;
    assign ifid_pc_plus = ifplus_q;
    assign ifid_valid   = valid_q;
    assign ifid_rs      = instr_q[7:4];
    assign ifid_rt      = instr_q[3:0];
    assign stall_count  = cnt_q;

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage plus IF/ID pipeline register, directly upstream of the hazard detection unit. It consumes pc_write/ifid_write, drives the IF/ID fields (rs, rt) that the hazard unit compares against ID/EX, and redirects on taken branches. It holds the PC, issues instruction-memory addresses, absorbs memory wait states by inserting bubbles, flushes on branch, and keeps a saturating stall counter.

Parameters:
ADDR_W, 16, PC / instruction-address width
INSTR_W, 16, instruction width; field layout opcode[15:12] rd[11:8] rs[7:4] rt[3:0]
RESET_PC, 0, PC value after reset
PC_INC, 2, byte increment per sequential fetch
CNT_W, 16, stall counter width

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
pc_write  in  1  from hazard unit; 0 = hold PC
ifid_write  in  1  from hazard unit; 0 = hold IF/ID register
branch_taken  in  1  redirect/flush request from EX
branch_target  in  ADDR_W  redirect address
imem_addr  out  ADDR_W  instruction memory address (= pc, combinational)
imem_rdata  in  INSTR_W  instruction word for imem_addr
imem_ready  in  1  imem_rdata valid this cycle
ifid_instr  out  INSTR_W  registered instruction (0 = NOP)
ifid_pc  out  ADDR_W  registered address of ifid_instr
ifid_pc_plus  out  ADDR_W  registered ifid_pc + PC_INC
ifid_valid  out  1  1 = real instruction, 0 = bubble
ifid_rs  out  4  ifid_instr[7:4], combinational from register
ifid_rt  out  4  ifid_instr[3:0], combinational from register
fetch_stall  out  1  ~imem_ready, combinational
stall_count  out  CNT_W  saturating count of stalled cycles

Behaviour:
- Reset (synchronous, on rst=1 at edge): pc=RESET_PC; ifid_instr=0, ifid_pc=0, ifid_pc_plus=0, ifid_valid=0; stall_count=0. Reset mid-operation discards in-flight fetch; overrides all other inputs.
- imem_addr = pc always; memory is zero-wait when imem_ready=1 in the same cycle.
- PC update priority per edge:
  1. rst -> RESET_PC
  2. branch_taken -> {branch_target[ADDR_W-1:1],1'b0} (bit 0 forced 0), regardless of pc_write/imem_ready
  3. pc_write & imem_ready -> pc + PC_INC, modulo 2^ADDR_W (wraps to 0, no flag)
  4. otherwise hold
- IF/ID register priority per edge:
  1. rst -> cleared
  2. branch_taken -> flush: ifid_instr=0, ifid_valid=0, ifid_pc/ifid_pc_plus hold
  3. ifid_write & imem_ready -> ifid_instr=imem_rdata, ifid_pc=pc, ifid_pc_plus=pc+PC_INC, ifid_valid=1
  4. ifid_write & ~imem_ready -> bubble: ifid_instr=0, ifid_valid=0, pc fields hold
  5. ~ifid_write -> hold all (hazard stall keeps instruction for re-check)
- Latency: instruction at pc appears on ifid_* one edge after a cycle with imem_ready=1, ifid_write=1, no branch.
- pc_write=0 with ifid_write=1 is legal: IF/ID reloads the same pc again (duplicate). The hazard unit never drives this; the bench must not rely on it.
- stall_count increments by 1 on each edge where (~pc_write | ~imem_ready) & ~branch_taken & ~rst. Saturates at 2^CNT_W-1, never wraps.
- Simultaneous branch_taken and hazard stall: branch wins; stalled instruction is wrong-path and is flushed.

Test Plan:
- Reset then imem_ready=1, pc_write=ifid_write=1, rdata=16'h1234,16'h5678 -> imem_addr 0,2,4; ifid_instr 1234 (pc 0, pc_plus 2, valid 1), then 5678 (pc 2); ifid_rs=3, ifid_rt=4 on first.
- Hazard stall: pc_write=ifid_write=0 for 2 cycles at pc=4 -> pc stays 4, ifid_* hold, stall_count +2; release -> next ifid_instr from pc 4.
- Memory wait: imem_ready=0 for 3 cycles at pc=6 -> pc holds 6, ifid_valid=0, ifid_instr=0 for those cycles, fetch_stall=1, stall_count +3; then instruction from 6 loads with valid=1.
- Branch during stall: pc_write=0 and branch_taken=1, target 16'h0041 -> pc=16'h0040, ifid_valid=0, instr=0, stall_count unchanged that edge.
- Wrap: branch to 16'hFFFE, run -> ifid_pc FFFE, ifid_pc_plus 0000, next imem_addr 0000.
- Saturation/reset: CNT_W=4, 20 stalled cycles -> stall_count=15; assert rst mid-fetch -> next edge pc=RESET_PC, all outputs zero.
